// File: rtl/line_buffer_3tap.sv
`default_nettype none
// ============================================================================
// Module     : line_buffer_3tap
// Description: Two-row line buffer that presents three vertically aligned
//              pixels (rows r-2, r-1, r) for a 3x3 convolution stage.
// Revision   : 1.0 - initial release
// ============================================================================
module line_buffer_3tap #(
    parameter int PIX_W     = 24,
    parameter int LINE_LEN  = 640,
    parameter int NUM_LINES = 480,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    input  logic              frame_start,
    output logic [PIX_W-1:0]  line0,
    output logic [PIX_W-1:0]  line1,
    output logic [PIX_W-1:0]  line2,
    output logic              taps_valid,
    output logic [ADDR_W-1:0] col_out,
    output logic [9:0]        row_out
);

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_col_last = ADDR_W'(LINE_LEN - 1);
    localparam logic [9:0]        c_row_last = 10'(NUM_LINES - 1);

    // ram_a holds row r-1, ram_b holds row r-2; contents are gated by state
    logic [PIX_W-1:0] ram_a [0:LINE_LEN-1];
    logic [PIX_W-1:0] ram_b [0:LINE_LEN-1];

    state_t            r_state;
    state_t            w_state_cur;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] w_col_cur;
    logic [ADDR_W-1:0] w_col_nxt;
    logic [9:0]        r_row;
    logic [9:0]        w_row_cur;
    logic [9:0]        w_row_nxt;
    logic              w_resync;

    // Position/state of the pixel being accepted: a resync overrides the counters
    always_comb begin
        w_resync    = pix_valid & frame_start;
        w_col_cur   = w_resync ? '0 : r_col;
        w_row_cur   = w_resync ? '0 : r_row;
        w_state_cur = w_resync ? FILL0 : r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_state_nxt = r_state;
        if (pix_valid) begin
            w_row_nxt   = w_row_cur;
            w_state_nxt = w_state_cur;
            if (w_col_cur == c_col_last) begin
                w_col_nxt = '0;
                if (w_row_cur == c_row_last) begin
                    w_row_nxt   = '0;
                    w_state_nxt = FILL0;
                end else begin
                    w_row_nxt = w_row_cur + 10'd1;
                    case (w_state_cur)
                        FILL0:   w_state_nxt = FILL1;
                        FILL1:   w_state_nxt = RUN;
                        default: w_state_nxt = RUN;
                    endcase
                end
            end else begin
                w_col_nxt = w_col_cur + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Row shift through the RAMs; reads below see the pre-write contents
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            ram_a[w_col_cur] <= pix_in;
            ram_b[w_col_cur] <= ram_a[w_col_cur];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line0      <= '0;
            line1      <= '0;
            line2      <= '0;
            taps_valid <= 1'b0;
            col_out    <= '0;
            row_out    <= '0;
        end else if (pix_valid) begin
            line0      <= ram_b[w_col_cur];
            line1      <= ram_a[w_col_cur];
            line2      <= pix_in;
            taps_valid <= (w_state_cur == RUN);
            col_out    <= w_col_cur;
            row_out    <= w_row_cur;
        end else begin
            taps_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
